// File: rtl/lsz_slot_alloc_if.sv
// lsz_slot_alloc_if: request/free/status bundle between a slot user and lsz_slot_alloc
//   master: drives alloc_req, free_vld, free_idx; observes grant and status
//   slave : drives alloc_gnt, alloc_idx, occ, cnt, full, empty, err_free
interface lsz_slot_alloc_if #(
   parameter int IWID = 4,
   parameter int IWL2 = $clog2(IWID)
);
   logic            alloc_req;
   logic            free_vld;
   logic [IWL2-1:0] free_idx;
   logic            alloc_gnt;
   logic [IWL2-1:0] alloc_idx;
   logic [IWID-1:0] occ;
   logic [IWL2:0]   cnt;
   logic            full;
   logic            empty;
   logic            err_free;
   modport master (
      output alloc_req, free_vld, free_idx,
      input  alloc_gnt, alloc_idx, occ, cnt, full, empty, err_free
   );
   modport slave (
      input  alloc_req, free_vld, free_idx,
      output alloc_gnt, alloc_idx, occ, cnt, full, empty, err_free
   );
endinterface

// File: rtl/lsz_slot_alloc.sv
// lsz_slot_alloc: busy-mask tracker granting the lowest free slot via an LSZ search
//   lsz           : in_i (mask) -> lszIdx (index of least-significant zero)
//   lsz_slot_alloc: clk, rst_n (async, active low), bus (slave modport of lsz_slot_alloc_if)
module lsz #(
   parameter int IWID = 4,
   parameter int IWL2 = $clog2(IWID)
) (
   input  logic [IWID-1:0] in_i,
   output logic [IWL2-1:0] lszIdx
);
   // scan from the top so the lowest zero wins; all-ones yields 0 (don't-care)
   always_comb begin
      lszIdx = '0;
      for (int i = IWID - 1; i >= 0; i--)
         if (!in_i[i]) lszIdx = IWL2'(i);
   end
endmodule

module lsz_slot_alloc #(
   parameter int IWID = 4,
   parameter int IWL2 = $clog2(IWID)
) (
   input logic                clk,
   input logic                rst_n,
   lsz_slot_alloc_if.slave    bus
);
   localparam logic [IWL2:0] FULL_CNT = (IWL2 + 1)'(IWID);
   logic [IWID-1:0] occ_q, occ_d;
   logic [IWL2:0]   cnt_q, cnt_d;
   logic [IWL2-1:0] idx_q, cand;
   logic            gnt_q, full_q, empty_q, err_q;
   logic            acc, legal, in_rng;
   lsz #(.IWID(IWID), .IWL2(IWL2)) u_lsz (.in_i(occ_q), .lszIdx(cand));
   // candidate comes from the pre-update mask, so a slot freed this cycle is
   // still busy here and cannot be re-granted in the same cycle
   always_comb begin
      acc    = bus.alloc_req & ~full_q;
      in_rng = {1'b0, bus.free_idx} < FULL_CNT;
      legal  = bus.free_vld & in_rng & (in_rng ? occ_q[bus.free_idx] : 1'b0);
      occ_d  = (occ_q & ~(legal ? IWID'(1) << bus.free_idx : '0))
             | (acc ? IWID'(1) << cand : '0);
      cnt_d  = cnt_q + (IWL2 + 1)'(acc) - (IWL2 + 1)'(legal);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         occ_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= 1'b0;
         idx_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
         gnt_q   <= acc;
         idx_q   <= acc ? cand : idx_q;
         full_q  <= cnt_d == FULL_CNT;
         empty_q <= cnt_d == '0;
         err_q   <= bus.free_vld & ~legal;
      end
   assign bus.occ       = occ_q;
   assign bus.cnt       = cnt_q;
   assign bus.alloc_gnt = gnt_q;
   assign bus.alloc_idx = idx_q;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.err_free  = err_q;
endmodule

// File: tb/tb_lsz_slot_alloc.sv
// tb_lsz_slot_alloc: directed self-checking bench for lsz_slot_alloc (IWID=4)
module tb_lsz_slot_alloc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   lsz_slot_alloc_if #(.IWID(4)) ifc ();
   lsz_slot_alloc #(.IWID(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input string tag, input logic gnt, input logic [1:0] idx,
                     input logic [3:0] occ, input logic [2:0] cnt,
                     input logic full, input logic empty, input logic err);
      chk({tag, ".gnt"},   32'(ifc.alloc_gnt), 32'(gnt));
      chk({tag, ".idx"},   32'(ifc.alloc_idx), 32'(idx));
      chk({tag, ".occ"},   32'(ifc.occ),       32'(occ));
      chk({tag, ".cnt"},   32'(ifc.cnt),       32'(cnt));
      chk({tag, ".full"},  32'(ifc.full),      32'(full));
      chk({tag, ".empty"}, 32'(ifc.empty),     32'(empty));
      chk({tag, ".err"},   32'(ifc.err_free),  32'(err));
   endtask

   always @(negedge clk)
      if (rst_n) chk("popcnt", 32'(ifc.cnt), 32'($countones(ifc.occ)));

   initial begin
      ifc.alloc_req = 1'b0;
      ifc.free_vld  = 1'b0;
      ifc.free_idx  = 2'd0;
      #12;
      st("reset", 0, 0, 4'b0000, 0, 0, 1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // fill from empty
      ifc.alloc_req = 1'b1;
      cyc(); st("fill0", 1, 0, 4'b0001, 1, 0, 0, 0);
      cyc(); st("fill1", 1, 1, 4'b0011, 2, 0, 0, 0);
      cyc(); st("fill2", 1, 2, 4'b0111, 3, 0, 0, 0);
      cyc(); st("fill3", 1, 3, 4'b1111, 4, 1, 0, 0);
      // full reject
      cyc(); st("rej0", 0, 3, 4'b1111, 4, 1, 0, 0);
      cyc(); st("rej1", 0, 3, 4'b1111, 4, 1, 0, 0);
      // hole reuse
      ifc.alloc_req = 1'b0; ifc.free_vld = 1'b1; ifc.free_idx = 2'd2;
      cyc(); st("hole_f2", 0, 3, 4'b1011, 3, 0, 0, 0);
      ifc.free_idx = 2'd0;
      cyc(); st("hole_f0", 0, 3, 4'b1010, 2, 0, 0, 0);
      ifc.free_vld = 1'b0; ifc.alloc_req = 1'b1;
      cyc(); st("hole_a0", 1, 0, 4'b1011, 3, 0, 0, 0);
      cyc(); st("hole_a2", 1, 2, 4'b1111, 4, 1, 0, 0);
      // simultaneous alloc+free while full
      ifc.free_vld = 1'b1; ifc.free_idx = 2'd1;
      cyc(); st("simfull", 0, 2, 4'b1101, 3, 0, 0, 0);
      ifc.free_vld = 1'b0;
      cyc(); st("simfull_retry", 1, 1, 4'b1111, 4, 1, 0, 0);
      // drain to 0011
      ifc.alloc_req = 1'b0; ifc.free_vld = 1'b1; ifc.free_idx = 2'd3;
      cyc(); st("drain3", 0, 1, 4'b0111, 3, 0, 0, 0);
      ifc.free_idx = 2'd2;
      cyc(); st("drain2", 0, 1, 4'b0011, 2, 0, 0, 0);
      // simultaneous alloc+free with space
      ifc.alloc_req = 1'b1; ifc.free_idx = 2'd0;
      cyc(); st("simspace", 1, 2, 4'b0110, 2, 0, 0, 0);
      // drain to empty
      ifc.alloc_req = 1'b0; ifc.free_idx = 2'd1;
      cyc(); st("drain1", 0, 2, 4'b0100, 1, 0, 0, 0);
      ifc.free_idx = 2'd2;
      cyc(); st("drainE", 0, 2, 4'b0000, 0, 0, 1, 0);
      // illegal free of an unoccupied slot
      ifc.free_idx = 2'd3;
      cyc(); st("illegal", 0, 2, 4'b0000, 0, 0, 1, 1);
      ifc.free_vld = 1'b0;
      cyc(); st("illegal_end", 0, 2, 4'b0000, 0, 0, 1, 0);
      // async reset mid-fill
      ifc.alloc_req = 1'b1;
      cyc(); st("mf0", 1, 0, 4'b0001, 1, 0, 0, 0);
      cyc(); st("mf1", 1, 1, 4'b0011, 2, 0, 0, 0);
      cyc(); st("mf2", 1, 2, 4'b0111, 3, 0, 0, 0);
      #1;
      rst_n = 1'b0;
      #1;
      st("async_rst", 0, 0, 4'b0000, 0, 0, 1, 0);
      ifc.alloc_req = 1'b0;
      cyc(); st("rst_hold", 0, 0, 4'b0000, 0, 0, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lsz_slot_alloc.md
Name: lsz_slot_alloc

Overview:
Occupancy tracker and free-slot allocator for IWID resources, such as unary bitstream generator lanes. It holds a busy mask and feeds it to an internal LSZ instance, which returns the index of the least-significant zero. That index is the lowest free slot, which the block grants on request. Released slots are cleared on free requests. The block sits directly upstream of LSZ and is its producer/consumer pair.

Parameters:
IWID, 4, number of slots (mask width); any value >= 2.
IWL2, $clog2(IWID), width of the slot index.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
alloc_req  input  1  request one free slot this cycle.
free_vld  input  1  release slot free_idx this cycle.
free_idx  input  IWL2  index of the slot to release.
alloc_gnt  output  1  registered; grant accepted, valid the cycle after the request.
alloc_idx  output  IWL2  registered; granted slot index.
occ  output  IWID  registered busy mask; bit i = 1 means slot i is occupied.
cnt  output  IWL2+1  registered count of occupied slots.
full  output  1  registered; cnt == IWID.
empty  output  1  registered; cnt == 0.
err_free  output  1  registered one-cycle pulse on an illegal free.

Behaviour:
- Reset (asynchronous, rst_n=0): occ=0, cnt=0, alloc_gnt=0, alloc_idx=0, full=0, empty=1, err_free=0. Asserting reset mid-operation discards all occupancy immediately.
- Internal LSZ instance (IWID=IWID) takes occ as its input. Its lszIdx is the candidate slot. The candidate is used only when full=0; its value when occ is all ones is don't-care.
- Allocation:
  - Condition: alloc_req=1 and full=0 at edge N.
  - Result at N+1: alloc_gnt=1, alloc_idx=candidate, occ[candidate]=1.
  - If alloc_req=1 and full=1: no grant; alloc_gnt=0 at N+1; no error.
  - Latency: 1 cycle. Throughput: one grant per cycle. Back-to-back requests from empty yield indices 0, 1, 2, ...
- alloc_gnt is 0 in any cycle without an accepted request. alloc_idx holds its last granted value when alloc_gnt=0.
- Free:
  - A legal free is free_vld=1, free_idx<IWID and occ[free_idx]=1. At N+1: occ[free_idx]=0.
  - An illegal free is free_vld=1 with free_idx>=IWID or occ[free_idx]=0. At N+1: err_free=1 for one cycle; occ and cnt are unchanged.
- Simultaneous alloc and free in the same cycle:
  - The candidate is computed from the pre-update occ, so the slot being freed is never re-granted in the same cycle.
  - If full=1, the free is applied and the alloc is rejected. The requester retries the next cycle.
  - An accepted alloc plus a legal free leaves cnt unchanged. Both occ bit updates apply.
- Count: cnt next = cnt + accepted_alloc - legal_free.
  - full and empty are registered from cnt next, so they always agree with occ in the same cycle.
  - cnt never exceeds IWID and never underflows.
- Invariant checked by the bench every cycle: cnt == popcount(occ).
- No combinational path from inputs to outputs; all outputs are flops.

Test Plan:
- Reset then fill (IWID=4): hold alloc_req=1 for 4 cycles -> grants on successive cycles with alloc_idx 0, 1, 2, 3; occ=4'b1111, cnt=4, full=1, empty=0.
- Full reject: with full=1, alloc_req=1 for 2 cycles -> alloc_gnt=0, occ unchanged, err_free=0.
- Hole reuse: from occ=1111, free idx 2 then idx 0, then one alloc -> occ goes 1011, then 1010, and the grant returns idx 0 (lowest free); occ=1011, cnt=3.
- Simultaneous with full=1: occ=1111, alloc_req=1 and free idx 1 in the same cycle -> no grant; occ=1101, cnt=3. The next-cycle alloc grants idx 1.
- Simultaneous with free space: occ=0011, alloc_req=1 and free idx 0 -> grant idx 2; occ=0110, cnt unchanged at 2.
- Illegal free: from empty, free idx 3 -> err_free pulses for 1 cycle, occ=0, cnt=0. Then reset asserted mid-fill (occ=0111) -> all outputs return to reset values asynchronously.
